mult16_rr_sched: RTL and testbench

- Round-robin scheduler that shares one signed 16x16 Booth-4/Wallace multiplier among NUM_REQ requesters.
- Each requester has a valid/ready request channel. The block owns the multiplier's operand registers and a result register, and returns each product tagged with the requester ID.
- The multiplier itself is combinational and is instantiated outside this block. It connects via mult_a/mult_b/mult_p.

---
 rtl/mult16_rr_sched.sv | 123 ++++++++++++
 tb/tb_mult16_rr_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult16_rr_sched.sv
// Round-robin front end for one shared signed 16x16 multiplier.
// S1 holds the registered operands feeding the external multiplier; S2
// captures its product together with the requester tag.
module mult16_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*16-1:0]   req_a,
    input  logic [NUM_REQ*16-1:0]   req_b,
    output logic [15:0]             mult_a,
    output logic [15:0]             mult_b,
    input  logic [31:0]             mult_p,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ID_W-1:0]         res_id,
    output logic [31:0]             res_data,
    output logic                    busy
);

    // packed per-lane views of the flat operand buses
    logic [NUM_REQ-1:0][15:0] a_vec, b_vec;
    assign a_vec = req_a;
    assign b_vec = req_b;

    logic            s1_valid_q, s1_valid_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic [15:0]     mult_a_q, mult_a_d, mult_b_q, mult_b_d;
    logic            res_valid_q, res_valid_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic [31:0]     res_data_q, res_data_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            s2_take, s1_take;
    logic            gnt_found;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W:0]   idx;
    logic            hs;

    assign s2_take = s1_valid_q && (!res_valid_q || res_ready);
    assign s1_take = !s1_valid_q || s2_take;
    // reset gating keeps the grant quiet while the async reset is held
    assign hs      = gnt_found && s1_take && sys_rst_n;

    // first valid requester at or after rr_ptr, wrapping at NUM_REQ
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
            if (!gnt_found && req_valid[idx[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = idx[ID_W-1:0];
            end
        end
        if (hs) req_ready[gnt_id] = 1'b1;
    end

    // pipeline advance: operands hold when S1 empties to avoid multiplier toggling
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        mult_a_d    = mult_a_q;
        mult_b_d    = mult_b_q;
        rr_ptr_d    = rr_ptr_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        if (s1_take) begin
            s1_valid_d = hs;
            if (hs) begin
                s1_id_d  = gnt_id;
                mult_a_d = a_vec[gnt_id];
                mult_b_d = b_vec[gnt_id];
                rr_ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
            end
        end
        if (s2_take) begin
            res_valid_d = 1'b1;
            res_id_d    = s1_id_q;
            res_data_d  = mult_p;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // state registers; reset discards anything in flight
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            rr_ptr_q    <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            mult_a_q    <= mult_a_d;
            mult_b_q    <= mult_b_d;
            rr_ptr_q    <= rr_ptr_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
        end
    end

    assign mult_a    = mult_a_q;
    assign mult_b    = mult_b_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
    assign busy      = s1_valid_q || res_valid_q;

endmodule

// File: tb/tb_mult16_rr_sched.sv
// Bench for mult16_rr_sched: behavioural multiplier, negedge scoreboard,
// one task per scenario.
module tb_mult16_rr_sched;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  sys_clk = 1'b0;
    logic                  sys_rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*16-1:0] req_a, req_b;
    logic [15:0]           mult_a, mult_b;
    logic [31:0]           mult_p;
    logic                  res_valid, res_ready;
    logic [ID_W-1:0]       res_id;
    logic [31:0]           res_data;
    logic                  busy;

    int errors = 0;
    int checks = 0;
    logic [ID_W+31:0] sb[$];

    always #5 sys_clk = ~sys_clk;

    assign mult_p = $signed(mult_a) * $signed(mult_b);

    mult16_rr_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_data(res_data), .busy(busy)
    );

    // scoreboard: handshakes and result transfers that the coming posedge commits
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (res_valid && res_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got id=%0d data=%h, none expected", res_id, res_data);
                end else begin
                    logic [ID_W+31:0] e;
                    e = sb.pop_front();
                    if ({res_id, res_data} !== e) begin
                        errors++;
                        $display("FAIL sb_result: got id=%0d data=%h, want id=%0d data=%h",
                                 res_id, res_data, e[ID_W+31:32], e[31:0]);
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    logic signed [31:0] p;
                    logic [15:0] a16, b16;
                    a16 = req_a[16*i +: 16];
                    b16 = req_b[16*i +: 16];
                    p = $signed(a16) * $signed(b16);
                    sb.push_back({ID_W'(i), p});
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        req_valid = '1;
        res_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        #1;
        checks++;
        if ({res_valid, busy, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: res_valid=%b busy=%b req_ready=%b, want 0", res_valid, busy, req_ready);
        end
        checks++;
        if ({mult_a, mult_b, res_id, res_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: a=%h b=%h id=%0d data=%h, want 0", mult_a, mult_b, res_id, res_data);
        end
        req_valid = '0;
        @(posedge sys_clk); #2;
        sys_rst_n = 1'b1;
    endtask

    task automatic test_single;
        @(posedge sys_clk); #1;
        set_req(0, 16'h7FFF, 16'h7FFF);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL single_grant: req_ready=%b want 0001", req_ready);
        end
        @(posedge sys_clk); #1;
        req_valid = '0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_s1: res_valid=%b busy=%b want 0 1", res_valid, busy);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 32'h3FFF0001) begin
            errors++;
            $display("FAIL single_res: v=%b id=%0d data=%h want 1 0 3fff0001", res_valid, res_id, res_data);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: res_valid=%b busy=%b want 0 0", res_valid, busy);
        end
    endtask

    task automatic test_corners;
        logic [15:0] ta[3];
        logic [15:0] tb[3];
        logic [31:0] tp[3];
        ta = '{16'h8000, 16'h8000, 16'hFFFF};
        tb = '{16'h8000, 16'h0001, 16'hFFFF};
        tp = '{32'h40000000, 32'hFFFF8000, 32'h00000001};
        for (int n = 0; n < 3; n++) begin
            @(posedge sys_clk); #1;
            set_req(1, ta[n], tb[n]);
            req_valid = 4'b0010;
            @(negedge sys_clk);
            checks++;
            if (req_ready !== 4'b0010) begin
                errors++; $display("FAIL corner_grant%0d: req_ready=%b want 0010", n, req_ready);
            end
            @(posedge sys_clk); #1;
            req_valid = '0;
            @(posedge sys_clk); #1;
            checks++;
            if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== tp[n]) begin
                errors++;
                $display("FAIL corner_res%0d: v=%b id=%0d data=%h want 1 1 %h", n, res_valid, res_id, res_data, tp[n]);
            end
        end
        @(posedge sys_clk); #1;
    endtask

    // rr_ptr is 2 here (last grant went to requester 1)
    task automatic test_all_rr;
        int prev;
        int want;
        prev = -1;
        res_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'($urandom), 16'($urandom));
        for (int k = 0; k < 16; k++) begin
            @(posedge sys_clk); #1;
            req_valid = '1;
            if (prev >= 0) set_req(prev, 16'($urandom), 16'($urandom));
            @(negedge sys_clk);
            want = (2 + k) % NUM_REQ;
            checks++;
            if (req_ready !== 4'(1 << want)) begin
                errors++; $display("FAIL rr_grant%0d: req_ready=%b want %b", k, req_ready, 4'(1 << want));
            end
            if (k >= 2) begin
                checks++;
                if (res_valid !== 1'b1) begin
                    errors++; $display("FAIL rr_thru%0d: res_valid=%b want 1", k, res_valid);
                end
            end
            prev = want;
        end
        @(posedge sys_clk); #1;
        req_valid = '0;
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    // rr_ptr is 2 here (last grant went to requester 1)
    task automatic test_backpressure;
        int hs_cnt;
        logic [31:0] held;
        hs_cnt = 0;
        held = '0;
        res_ready = 1'b0;
        set_req(2, 16'($urandom), 16'($urandom));
        for (int k = 0; k < 5; k++) begin
            @(posedge sys_clk); #1;
            req_valid = 4'b0100;
            if (k > 0 && hs_cnt == k) set_req(2, 16'($urandom), 16'($urandom));
            @(negedge sys_clk);
            if (req_valid[2] && req_ready[2]) hs_cnt++;
            if (k == 2) held = res_data;
            if (k > 2) begin
                checks++;
                if (res_valid !== 1'b1 || res_data !== held) begin
                    errors++; $display("FAIL bp_hold%0d: v=%b data=%h want 1 %h", k, res_valid, res_data, held);
                end
            end
        end
        checks++;
        if (hs_cnt != 2 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_accept: handshakes=%0d req_ready=%b want 2 0000", hs_cnt, req_ready);
        end
        @(posedge sys_clk); #1;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL bp_drain: busy=%b pending=%0d want 0 0", busy, sb.size());
        end
    endtask

    // rr_ptr is 3 here (last grant went to requester 2)
    task automatic test_wrap;
        @(posedge sys_clk); #1;
        set_req(1, 16'd3, 16'd5);
        req_valid = 4'b0010;
        @(negedge sys_clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL wrap_skip: req_ready=%b want 0010", req_ready);
        end
        @(posedge sys_clk); #1;
        set_req(0, 16'd7, 16'hFFF9);
        set_req(3, 16'hFFFE, 16'd9);
        req_valid = 4'b1001;
        @(negedge sys_clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL wrap_ptr: req_ready=%b want 1000", req_ready);
        end
        @(posedge sys_clk); #1;
        req_valid = 4'b0001;
        @(negedge sys_clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL wrap_zero: req_ready=%b want 0001", req_ready);
        end
        @(posedge sys_clk); #1;
        req_valid = '0;
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    // rr_ptr is 1 here; fill S1 and S2, then reset asynchronously
    task automatic test_reset_mid;
        res_ready = 1'b0;
        set_req(1, 16'h1234, 16'h0042);
        req_valid = 4'b0010;
        repeat (2) @(posedge sys_clk);
        #1;
        req_valid = 4'b1111;
        #2;
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b1) begin
            errors++; $display("FAIL rstm_full: busy=%b res_valid=%b want 1 1", busy, res_valid);
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rstm_clear: res_valid=%b busy=%b req_ready=%b want 0 0 0000", res_valid, busy, req_ready);
        end
        sb.delete();
        res_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'(i + 2), 16'(i + 10));
        @(posedge sys_clk); #3;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL rstm_first: req_ready=%b want 0001", req_ready);
        end
        @(posedge sys_clk); #1;
        req_valid = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL final_drain: pending=%0d busy=%b want 0 0", sb.size(), busy);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_corners;
        test_all_rr;
        test_backpressure;
        test_wrap;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
